// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: in-order IM requests with credit flow control, a small
// instruction buffer, and the IF/ID register with stall and redirect handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_req_addr,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IF_pc_out,
    output logic [31:0] IF_instr_out,
    output logic        IF_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_sum;

    logic [31:0]   tag_q     [DEPTH];
    logic [PW-1:0] tag_wr, tag_rd;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [PW-1:0] buf_wr, buf_rd;

    logic req_fire, rsp_fire, rsp_keep;
    logic buf_empty, load_buf, load_byp, buf_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        credit_sum   = {1'b0, outstanding} + {1'b0, buf_count};
        im_req_valid = (credit_sum < (CW+1)'(DEPTH)) && !redirect_valid && !rst;
        im_req_addr  = fetch_pc;
        req_fire     = im_req_valid && im_req_ready;
        rsp_fire     = im_rsp_valid && (outstanding != '0);
        // Responses arriving with a redirect belong to the wrong path as well.
        rsp_keep     = rsp_fire && (drop_cnt == '0) && !redirect_valid;
        buf_empty    = (buf_count == '0);
        load_buf     = !redirect_valid && !stall && !buf_empty;
        load_byp     = !redirect_valid && !stall && buf_empty && rsp_keep;
        buf_push     = rsp_keep && !load_byp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            outstanding  <= '0;
            drop_cnt     <= '0;
            tag_wr       <= '0;
            tag_rd       <= '0;
            buf_count    <= '0;
            buf_wr       <= '0;
            buf_rd       <= '0;
            IF_pc_out    <= '0;
            IF_instr_out <= NOP_INSTR;
            IF_valid     <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (req_fire) tag_wr <= ptr_inc(tag_wr);
            if (rsp_fire) tag_rd <= ptr_inc(tag_rd);

            if (redirect_valid) begin
                // Everything still in flight after this edge is wrong-path.
                fetch_pc     <= redirect_pc;
                drop_cnt     <= outstanding - CW'(rsp_fire);
                buf_count    <= '0;
                buf_wr       <= '0;
                buf_rd       <= '0;
                IF_instr_out <= NOP_INSTR;
                IF_valid     <= 1'b0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                buf_count <= buf_count + CW'(buf_push) - CW'(load_buf);
                if (buf_push) buf_wr <= ptr_inc(buf_wr);
                if (load_buf) buf_rd <= ptr_inc(buf_rd);

                if (stall) begin
                    IF_valid <= IF_valid;
                end else if (load_buf) begin
                    IF_pc_out    <= buf_pc[buf_rd];
                    IF_instr_out <= buf_instr[buf_rd];
                    IF_valid     <= 1'b1;
                end else if (load_byp) begin
                    IF_pc_out    <= tag_q[tag_rd];
                    IF_instr_out <= im_rsp_data;
                    IF_valid     <= 1'b1;
                end else begin
                    IF_instr_out <= NOP_INSTR;
                    IF_valid     <= 1'b0;
                end
            end
        end
    end

    // Queue payloads carry no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= fetch_pc;
        if (buf_push) begin
            buf_pc[buf_wr]    <= tag_q[tag_rd];
            buf_instr[buf_wr] <= im_rsp_data;
        end
    end

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(im_rsp_valid && outstanding == '0));
    credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_sum <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: in-order IM model with variable latency and a
// program-order reference for the IF/ID stream, plus a second instance for PC wrap.
module tb_if_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req_valid, im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid;
    logic [31:0] im_rsp_data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_pc, if_instr;
    logic        if_valid;

    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_stall, w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc, w_instr;
    logic        w_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .im_req_valid(im_req_valid), .im_req_ready(im_req_ready), .im_req_addr(im_req_addr),
        .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IF_pc_out(if_pc), .IF_instr_out(if_instr), .IF_valid(if_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst),
        .im_req_valid(w_req_valid), .im_req_ready(w_req_ready), .im_req_addr(w_req_addr),
        .im_rsp_valid(w_rsp_valid), .im_rsp_data(w_rsp_data),
        .stall(w_stall), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .IF_pc_out(w_pc), .IF_instr_out(w_instr), .IF_valid(w_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference state: IM in-flight queue, drop count, program-order expectations.
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          drop_n, kept, loaded, hs_count, lat_min, lat_max;
    logic [31:0] fetch_exp, exp_pc, last_hs_addr;
    logic [31:0] prev_pc, prev_instr;
    logic        prev_valid;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_due.delete();
        drop_n = 0; kept = 0; loaded = 0;
        fetch_exp = 32'h0; exp_pc = 32'h0;
        prev_pc = 32'h0; prev_instr = NOP; prev_valid = 1'b0;
        im_rsp_valid = 1'b0; im_rsp_data = 32'h0;
    endtask

    // Called at a negedge with stall/redirect/ready already set; returns at the next negedge.
    task automatic cycle();
        logic rsp, hs, keep, was_buf, exp_v, exp_rv;
        int   due;
        rsp = (q_addr.size() > 0) && (q_due[0] <= cyc);
        im_rsp_valid = rsp;
        im_rsp_data  = rsp ? instr_of(q_addr[0]) : 32'h0;
        #4;
        exp_rv = ((q_addr.size() + (kept - loaded)) < DEPTH) && !redirect_valid;
        chk("req_valid", im_req_valid, exp_rv);
        if (im_req_valid) chk("req_addr", im_req_addr, fetch_exp);
        hs = im_req_valid && im_req_ready;
        @(posedge clk);
        #1;
        if (rsp) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        keep = rsp && (drop_n == 0) && !redirect_valid;
        if (rsp && drop_n > 0) drop_n--;
        was_buf = (kept - loaded) > 0;
        if (hs) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (q_due.size() > 0 && q_due[$] > due) due = q_due[$];
            q_addr.push_back(fetch_exp);
            q_due.push_back(due);
            last_hs_addr = fetch_exp;
            fetch_exp += 32'd4;
            hs_count++;
        end
        if (keep) kept++;
        if (redirect_valid) begin
            chk("redir_valid", if_valid, 1'b0);
            chk("redir_instr", if_instr, NOP);
            chk("redir_pc_hold", if_pc, prev_pc);
            drop_n = q_addr.size();
            kept = loaded;
            exp_pc = redirect_pc;
            fetch_exp = redirect_pc;
        end else if (stall) begin
            chk("stall_pc", if_pc, prev_pc);
            chk("stall_instr", if_instr, prev_instr);
            chk("stall_valid", if_valid, prev_valid);
        end else begin
            exp_v = was_buf || keep;
            chk("if_valid", if_valid, exp_v);
            if (exp_v) begin
                chk("if_pc", if_pc, exp_pc);
                chk("if_instr", if_instr, instr_of(exp_pc));
                loaded++;
                exp_pc += 32'd4;
            end else begin
                chk("bubble_instr", if_instr, NOP);
                chk("bubble_pc", if_pc, prev_pc);
            end
        end
        prev_pc = if_pc; prev_instr = if_instr; prev_valid = if_valid;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int h0, found, ld0, nw;
        logic        w_pend;
        logic [31:0] w_pend_addr;

        rst = 1'b1; im_req_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
        w_stall = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;
        hs_count = 0; last_hs_addr = 32'h0; lat_min = 1; lat_max = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_req_valid", im_req_valid, 1'b0);
        chk("rst_w_req_valid", w_req_valid, 1'b0);

        // Back-to-back fetch with a 1-cycle IM.
        rst = 1'b0; im_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i >= 1) begin
                chk("thru_valid", if_valid, 1'b1);
                chk("seq_pc", if_pc, 32'(4 * (i - 1)));
            end
        end

        // Four-cycle stall mid-stream.
        stall = 1'b1; h0 = hs_count;
        for (int i = 0; i < 4; i++) cycle();
        chk("stall_hs_bound", 32'(hs_count - h0 <= 2), 32'h1);
        stall = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Redirect with two fetches in flight.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 12 && q_addr.size() != 2; i++) cycle();
        chk("inflight2", 32'(q_addr.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0; lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            cycle();
            if (if_valid) found = 1;
        end
        chk("redir_found", 32'(found), 32'd1);
        chk("redir_first_pc", if_pc, 32'h100);

        // Redirect and stall together.
        stall = 1'b1;
        for (int i = 0; i < 2; i++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        chk("rs_valid", if_valid, 1'b0);
        redirect_valid = 1'b0;
        cycle();
        stall = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("rs_resume", if_pc >= 32'h200 && if_pc < 32'h240, 1'b1);

        // Random traffic.
        lat_min = 1; lat_max = 4; ld0 = loaded;
        for (int i = 0; i < 3000; i++) begin
            im_req_ready   = ($urandom % 4) != 0;
            stall          = ($urandom % 5) == 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            cycle();
        end
        stall = 1'b0; redirect_valid = 1'b0;
        chk("progress", 32'(loaded - ld0 > 300), 32'h1);

        // Ready held low, then asynchronous reset mid-wait.
        im_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, NOP);
        chk("arst_valid", if_valid, 1'b0);
        chk("arst_req_valid", im_req_valid, 1'b0);
        model_reset();
        lat_min = 1; lat_max = 1;
        @(negedge clk);
        rst = 1'b0; im_req_ready = 1'b1; h0 = hs_count;
        cycle();
        chk("post_rst_hs", 32'(hs_count - h0), 32'd1);
        chk("post_rst_addr", last_hs_addr, 32'h0);
        for (int i = 0; i < 4; i++) cycle();

        // PC wrap on the second instance.
        im_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0; w_req_ready = 1'b1; im_req_ready = 1'b0;
        w_pend = 1'b0; w_pend_addr = 32'h0; nw = 0;
        for (int i = 0; i < 5; i++) begin
            logic        hs_w;
            logic [31:0] a_w;
            w_rsp_valid = w_pend;
            w_rsp_data  = instr_of(w_pend_addr);
            #4;
            hs_w = w_req_valid && w_req_ready;
            a_w  = w_req_addr;
            if (hs_w) begin
                chk("wrap_addr", a_w, 32'hFFFF_FFF8 + 32'(4 * nw));
                nw++;
            end
            @(posedge clk);
            #1;
            if (w_rsp_valid) begin
                chk("wrap_if_pc", w_pc, w_pend_addr);
                chk("wrap_if_instr", w_instr, instr_of(w_pend_addr));
                chk("wrap_if_valid", w_valid, 1'b1);
            end
            w_pend = hs_w; w_pend_addr = a_w;
            @(negedge clk);
        end
        chk("wrap_count", 32'(nw >= 3), 32'h1);
        w_rsp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
